// File: rtl/seg_mux_scanner.sv
// Multiplexed 7-segment scanner: prescaled digit slots, per-frame snapshot.
// Optional leading-zero suppression with SEG_LZ_BLANK_EN.
module seg_mux_scanner #(
   parameter int NDIGITS  = 4,
   parameter int PRESCALE = 100000,
   parameter int GUARD    = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [4*NDIGITS-1:0] digits,
   input  logic [NDIGITS-1:0]   dp_in,
   input  logic                 blank,
   output logic                 segA,
   output logic                 segB,
   output logic                 segC,
   output logic                 segD,
   output logic                 segE,
   output logic                 segF,
   output logic                 segG,
   output logic                 segDP,
   output logic [NDIGITS-1:0]   anode,
   output logic                 frame_tick
);

   localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;

   logic [CW-1:0]        cnt;
   logic [IW-1:0]        idx;
   logic [4*NDIGITS-1:0] snap;
   logic [NDIGITS-1:0]   dpSnap;

   logic                 slotEnd;
   logic                 frameEnd;
   logic                 lit;
   logic [3:0]           curDigit;
   logic [6:0]           decoded;
   logic [6:0]           segNext;
   logic [NDIGITS-1:0]   oneHot;
`ifdef SEG_LZ_BLANK_EN
   logic [NDIGITS-1:0]   lzMask;
   logic                 allZero;
`endif

   always_comb begin
      slotEnd  = (cnt == CW'(PRESCALE - 1));
      frameEnd = slotEnd && (idx == IW'(NDIGITS - 1));
      lit      = !blank && (cnt >= CW'(GUARD));
      curDigit = snap[4*idx +: 4];
      oneHot   = '0;
      oneHot[idx] = 1'b1;
      // bit 6 = A ... bit 0 = G
      unique case (curDigit)
         4'd0:    decoded = 7'h7E;
         4'd1:    decoded = 7'h30;
         4'd2:    decoded = 7'h6D;
         4'd3:    decoded = 7'h79;
         4'd4:    decoded = 7'h33;
         4'd5:    decoded = 7'h5B;
         4'd6:    decoded = 7'h5F;
         4'd7:    decoded = 7'h70;
         4'd8:    decoded = 7'h7F;
         4'd9:    decoded = 7'h7B;
         default: decoded = 7'h01;
      endcase
`ifdef SEG_LZ_BLANK_EN
      // A digit is a leading zero if it and everything above it is zero.
      allZero = 1'b1;
      lzMask  = '0;
      for (int i = NDIGITS - 1; i > 0; i--) begin
         allZero   = allZero && (snap[4*i +: 4] == 4'd0);
         lzMask[i] = allZero;
      end
      segNext = lzMask[idx] ? 7'h00 : decoded;
`else
      segNext = decoded;
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt        <= '0;
         idx        <= '0;
         snap       <= '0;
         dpSnap     <= '0;
         anode      <= '0;
         {segA, segB, segC, segD, segE, segF, segG} <= 7'h00;
         segDP      <= 1'b0;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= frameEnd;
         cnt        <= slotEnd ? '0 : cnt + CW'(1);
         if (slotEnd)
            idx <= frameEnd ? '0 : idx + IW'(1);
         if (frameEnd) begin
            snap   <= digits;
            dpSnap <= dp_in;
         end
         anode <= lit ? oneHot : '0;
         {segA, segB, segC, segD, segE, segF, segG} <= lit ? segNext : 7'h00;
         segDP <= lit && dpSnap[idx];
      end
   end

endmodule

// File: tb/tb_seg_mux_scanner.sv
// Directed bench for seg_mux_scanner (NDIGITS=4, PRESCALE=8, GUARD=2).
// Honours SEG_LZ_BLANK_EN in its expectation model.
module tb_seg_mux_scanner;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] digits;
   logic [3:0]  dp_in;
   logic        blank;
   logic        segA, segB, segC, segD, segE, segF, segG, segDP;
   logic [3:0]  anode;
   logic        frame_tick;
   logic [6:0]  segs;

   int nRun  = 0;
   int nFail = 0;

   assign segs = {segA, segB, segC, segD, segE, segF, segG};

   always #5 clk = ~clk;

   seg_mux_scanner #(.NDIGITS(4), .PRESCALE(8), .GUARD(2)) dut (
      .clk(clk), .rst(rst), .digits(digits), .dp_in(dp_in),
      .blank(blank), .segA(segA), .segB(segB), .segC(segC),
      .segD(segD), .segE(segE), .segF(segF), .segG(segG),
      .segDP(segDP), .anode(anode), .frame_tick(frame_tick)
   );

   function automatic logic [6:0] segOf(input logic [3:0] d);
      case (d)
         4'd0:    return 7'b1111110;
         4'd1:    return 7'b0110000;
         4'd2:    return 7'b1101101;
         4'd3:    return 7'b1111001;
         4'd4:    return 7'b0110011;
         4'd5:    return 7'b1011011;
         4'd6:    return 7'b1011111;
         4'd7:    return 7'b1110000;
         4'd8:    return 7'b1111111;
         4'd9:    return 7'b1111011;
         default: return 7'b0000001;
      endcase
   endfunction

   // Expected {anode, segs, segDP, frame_tick} at offset t after frame_tick.
   function automatic logic [12:0] expOut(input int t, input logic [15:0] s,
                                          input logic [3:0] dp, input bit blk);
      int         i;
      bit         on;
      logic [6:0] sg;
      logic [3:0] an;
      logic       tk;
`ifdef SEG_LZ_BLANK_EN
      bit         lz;
`endif
      i  = (t - 1) / 8;
      on = ((t - 1) % 8 >= 2) && !blk;
      sg = segOf(s[4*i +: 4]);
`ifdef SEG_LZ_BLANK_EN
      lz = (i > 0);
      for (int j = i; j < 4; j++)
         if (s[4*j +: 4] != 4'd0) lz = 0;
      if (lz) sg = 7'b0;
`endif
      an = 4'b0001 << i;
      tk = (t == 32);
      if (on) return {an, sg, dp[i], tk};
      return {4'b0, 7'b0, 1'b0, tk};
   endfunction

   task automatic waitFrame(input string name);
      bit seen = 0;
      for (int c = 0; c < 64 && !seen; c++) begin
         @(negedge clk);
         seen = frame_tick;
      end
      nRun++;
      if (!seen) begin
         nFail++;
         $display("FAIL %s: frame_tick got 0 within 64 cycles, want 1", name);
      end
   endtask

   task automatic test_reset;
      logic [12:0] e;
      rst = 1; digits = '0; dp_in = '0; blank = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         nRun++;
         if ({anode, segs, segDP, frame_tick} !== 13'b0) begin
            nFail++;
            $display("FAIL reset_hold c=%0d got %b want 0", c,
                     {anode, segs, segDP, frame_tick});
         end
      end
      rst = 0;
      digits = 16'h4321;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         e = (c >= 2) ? {4'b0001, 7'b1111110, 1'b0, 1'b0} : 13'b0;
         nRun++;
         if ({anode, segs, segDP, frame_tick} !== e) begin
            nFail++;
            $display("FAIL reset_release c=%0d got %b want %b", c,
                     {anode, segs, segDP, frame_tick}, e);
         end
      end
   endtask

   task automatic test_scan_order;
      logic [12:0] e;
      waitFrame("scan_wait");
      for (int t = 1; t <= 32; t++) begin
         @(negedge clk);
         e = expOut(t, 16'h4321, 4'b0, 0);
         nRun++;
         if ({anode, segs, segDP, frame_tick} !== e) begin
            nFail++;
            $display("FAIL scan_order t=%0d got %b want %b", t,
                     {anode, segs, segDP, frame_tick}, e);
         end
      end
   endtask

   task automatic test_no_tearing;
      logic [12:0] e;
      digits = 16'h1111;
      waitFrame("tear_wait");
      for (int t = 1; t <= 32; t++) begin
         @(negedge clk);
         e = expOut(t, 16'h1111, 4'b0, 0);
         nRun++;
         if ({anode, segs, segDP, frame_tick} !== e) begin
            nFail++;
            $display("FAIL tear_old t=%0d got %b want %b", t,
                     {anode, segs, segDP, frame_tick}, e);
         end
         if (t == 12) digits = 16'h9999;
      end
      for (int t = 1; t <= 32; t++) begin
         @(negedge clk);
         e = expOut(t, 16'h9999, 4'b0, 0);
         nRun++;
         if ({anode, segs, segDP, frame_tick} !== e) begin
            nFail++;
            $display("FAIL tear_new t=%0d got %b want %b", t,
                     {anode, segs, segDP, frame_tick}, e);
         end
      end
   endtask

   task automatic test_blank_dp;
      logic [12:0] e;
      dp_in = 4'b0100;
      waitFrame("blank_wait");
      for (int t = 1; t <= 32; t++) begin
         @(negedge clk);
         e = expOut(t, 16'h9999, 4'b0100, (t >= 13 && t <= 22));
         nRun++;
         if ({anode, segs, segDP, frame_tick} !== e) begin
            nFail++;
            $display("FAIL blank_dp t=%0d got %b want %b", t,
                     {anode, segs, segDP, frame_tick}, e);
         end
         blank = (t >= 12 && t <= 21);
      end
   endtask

   task automatic test_decode;
      logic [12:0] e;
      logic [15:0] pat [2];
      pat[0] = 16'h8A65;
      pat[1] = 16'hFEDB;
      digits = pat[0];
      dp_in  = 4'b0;
      waitFrame("decode_wait");
      for (int f = 0; f < 2; f++) begin
         for (int t = 1; t <= 32; t++) begin
            @(negedge clk);
            e = expOut(t, pat[f], 4'b0, 0);
            nRun++;
            if ({anode, segs, segDP, frame_tick} !== e) begin
               nFail++;
               $display("FAIL decode f=%0d t=%0d got %b want %b", f, t,
                        {anode, segs, segDP, frame_tick}, e);
            end
            if (t == 1) digits = pat[1];
         end
      end
   endtask

   task automatic test_invalid_rst;
      logic [12:0] e;
      digits = 16'h0C00;
      dp_in  = 4'b0100;
      waitFrame("inval_wait");
      for (int t = 1; t <= 20; t++) begin
         @(negedge clk);
         e = expOut(t, 16'h0C00, 4'b0100, 0);
         nRun++;
         if ({anode, segs, segDP, frame_tick} !== e) begin
            nFail++;
            $display("FAIL invalid t=%0d got %b want %b", t,
                     {anode, segs, segDP, frame_tick}, e);
         end
      end
      rst = 1;
      @(negedge clk);
      nRun++;
      if ({anode, segs, segDP, frame_tick} !== 13'b0) begin
         nFail++;
         $display("FAIL mid_rst got %b want 0",
                  {anode, segs, segDP, frame_tick});
      end
      rst = 0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         e = (c == 2) ? {4'b0001, 7'b1111110, 1'b0, 1'b0} : 13'b0;
         nRun++;
         if ({anode, segs, segDP, frame_tick} !== e) begin
            nFail++;
            $display("FAIL rst_restart c=%0d got %b want %b", c,
                     {anode, segs, segDP, frame_tick}, e);
         end
      end
   endtask

   task automatic test_lz;
      logic [12:0] e;
      digits = 16'h0070;
      dp_in  = 4'b0;
      waitFrame("lz_wait");
      for (int t = 1; t <= 32; t++) begin
         @(negedge clk);
         e = expOut(t, 16'h0070, 4'b0, 0);
         nRun++;
         if ({anode, segs, segDP, frame_tick} !== e) begin
            nFail++;
            $display("FAIL lz t=%0d got %b want %b", t,
                     {anode, segs, segDP, frame_tick}, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_scan_order();
      test_no_tearing();
      test_blank_dp();
      test_decode();
      test_invalid_rst();
      test_lz();
      $display("[TB] %0d tests run, %0d failed", nRun, nFail);
      $finish;
   end

endmodule

// File: doc/seg_mux_scanner.md
Name: seg_mux_scanner

Overview:
Downstream display stage for the BCD counter projects. Drives a multi-digit, common-segment 7-segment display by time-multiplexing NDIGITS BCD digits onto one shared segment bus and a one-hot digit enable. The BCD-to-segment decode is internal, so the BCD counter outputs connect directly. All logic runs on the board clock. Scan timing comes from an internal prescaler enable, not a derived clock.

Parameters:
NDIGITS, 4, number of digits scanned (1..8)
PRESCALE, 100000, clk cycles each digit is active per scan slot (>= 4)
GUARD, 16, cycles at the start of each slot with all anodes off, for anti-ghosting (1 <= GUARD < PRESCALE)

Ports:
clk  input  1  board clock; sole clock
rst  input  1  synchronous, active-high reset
digits  input  4*NDIGITS  BCD digits; digit i = digits[4i+3:4i]; i=0 least significant (rightmost)
dp_in  input  NDIGITS  decimal point request per digit
blank  input  1  1 = all anodes off; scanning continues
segA..segG  output  1 each  segment drives, active-high (1 = lit)
segDP  output  1  decimal point drive, active-high
anode  output  NDIGITS  one-hot digit enable, active-high
frame_tick  output  1  one-cycle pulse when a new digit snapshot is taken

Behaviour:
- Clock/reset: single clock. Reset is synchronous and active-high. Every register is assigned on rst=1.
- Reset values: cnt=0, idx=0, snap=0, anode=0, all seg*=0, segDP=0, frame_tick=0.
- Prescaler cnt: width $clog2(PRESCALE). It increments every cycle. At cnt==PRESCALE-1, cnt returns to 0 and idx advances.
- idx advance: idx <= idx+1. From NDIGITS-1 it wraps to 0.
- Snapshot:
  - At cnt==PRESCALE-1 with idx==NDIGITS-1, snap <= digits and dp_snap <= dp_in.
  - frame_tick is registered high for exactly the following cycle.
  - Input changes are not visible until the next frame, so a frame never tears.
  - The first frame after reset displays snap=0.
- Registered outputs: all outputs are registered and use (cnt, idx, snap) from the previous cycle, giving one cycle of latency.
  - If blank==1 or cnt<GUARD: anode=0, seg*=0, segDP=0.
  - Otherwise: anode = one-hot(idx); seg* = decode(snap digit idx); segDP = dp_snap[idx].
- Decode (segments A..G, 1=lit):
  0=ABCDEF, 1=BC, 2=ABDEG, 3=ABCDG, 4=BCFG, 5=ACDFG, 6=ACDEFG, 7=ABC, 8=ABCDEFG, 9=ABCDFG.
- Non-BCD digits (10..15) display a dash: G only.
- Anode invariant: at most one anode bit is high in any cycle.
- Slot timing: each digit is lit for PRESCALE-GUARD consecutive cycles per slot. Full frame period = NDIGITS*PRESCALE cycles.
- blank timing: takes effect one cycle after assertion and does not disturb cnt, idx or snapshot timing.
- Reset mid-scan: on the cycle after rst is sampled high, all outputs are 0. Scanning restarts at idx=0, cnt=0.
- NDIGITS=1: idx stays 0, and a snapshot is taken every PRESCALE cycles.

Optional Feature:
Macro SEG_LZ_BLANK_EN.
- Defined: leading-zero suppression.
  - Digit i (i>0) shows seg*=0 when snap digit i and every more-significant digit are 0.
  - Digit 0 is always displayed.
  - The anode still asserts normally, and segDP still follows dp_snap.
  - The suppression mask is computed from snap only.
- Undefined: all digits are decoded normally, and zeros are displayed.

Test Plan:
All scenarios use NDIGITS=4, PRESCALE=8, GUARD=2.
1. Reset: hold rst 3 cycles, release. During reset and the cycle after, anode=0000 and seg*=0. First lit anode=0001 at cnt=2 (+1 latency), displaying "0" (ABCDEF).
2. Scan order: digits=16'h4321 applied before the first frame boundary. After frame_tick, observe anode 0001/0010/0100/1000, each 6 cycles high and 2 cycles dark. Segments in order: 1=BC, 2=ABDEG, 3=ABCDG, 4=BCFG. Frame period is 32 cycles.
3. No tearing: change digits from 16'h1111 to 16'h9999 mid-frame. The current frame shows all 1s. The next frame, after frame_tick, shows all 9s (ABCDFG).
4. blank and dp: dp_in=4'b0100, blank pulsed for 10 cycles mid-slot. anode=0 exactly from the cycle after blank rises to the cycle after it falls. idx continues advancing. segDP=1 only while anode=0100.
5. Invalid and rst mid-operation: digit value 4'hC shows G only. Asserting rst while anode=0100 gives all outputs 0 on the next cycle, and scanning restarts at 0001.
6. SEG_LZ_BLANK_EN: digits=16'h0070 shows segs off for digits 3 and 2, "7" on digit 1, "0" on digit 0. Without the macro, "0070" is shown in full.
